// File: rtl/game_ctrl.sv
// game_ctrl: frame tick, IDLE/RUN/OVER sequencer, collision latch and 4-digit BCD score.
// Define GAME_CTRL_PAUSE_EN to add a PAUSE state toggled by START while running.
module game_ctrl #(
  parameter int unsigned ACTIVE_ROWS = 480,
  parameter int unsigned SCORE_DIV   = 6
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        dino_px,
  input  logic        obst_px,
  output logic        fresh,
  output logic        game_status,
  output logic        game_over,
  output logic [15:0] score
);

  localparam logic [9:0] ROW_LIMIT = 10'(ACTIVE_ROWS);
  localparam logic [9:0] COL_LIMIT = 10'd640;
  localparam logic [7:0] DIV_LAST  = 8'(SCORE_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_OVER  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic        r_start_p;
  logic        r_fresh;
  logic        r_fresh_d;
  logic        r_frame_end;
  logic        r_hit;
  logic [7:0]  r_frame_cnt;
  logic [15:0] r_score;
  logic        r_game_status;
  logic        r_game_over;
  logic        w_row_active;
  logic        w_hit_now;

  // Saturating BCD increment; a 9 rolls to 0 and carries into the next digit.
  function automatic logic [15:0] bcd_inc(input logic [15:0] val);
    logic [15:0] res;
    logic        carry;
    res   = val;
    carry = 1'b1;
    if (val == 16'h9999) begin
      carry = 1'b0;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (res[d*4 +: 4] == 4'd9) begin
            res[d*4 +: 4] = 4'd0;
          end else begin
            res[d*4 +: 4] = res[d*4 +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

  assign w_row_active = ({1'b0, row_addr} < ROW_LIMIT);
  assign w_hit_now    = dino_px & obst_px & (col_addr < COL_LIMIT) & w_row_active;

  // START synchroniser and registered rising-edge pulse
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_start_p <= 1'b0;
    end else begin
      r_sync1   <= START;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_start_p <= r_sync2 & ~r_sync3;
    end
  end

  // Frame tick and the one-cycle end-of-frame strobe that trails its fall
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fresh     <= 1'b0;
      r_fresh_d   <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_fresh     <= w_row_active;
      r_fresh_d   <= r_fresh;
      r_frame_end <= r_fresh_d & ~r_fresh;
    end
  end

  // Game sequencer: state, collision latch, frame divider, score and status outputs
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_IDLE;
      r_hit         <= 1'b0;
      r_frame_cnt   <= 8'd0;
      r_score       <= 16'h0000;
      r_game_status <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_OVER: begin
          if (r_start_p) begin
            r_state       <= S_RUN;
            r_hit         <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_score       <= 16'h0000;
            r_game_status <= 1'b1;
            r_game_over   <= 1'b0;
          end else begin
            r_hit <= w_hit_now | (r_hit & ~r_frame_end);
          end
        end
        S_RUN: begin
          // The latch is judged on frame_end before that same strobe clears it.
          if (r_frame_end && r_hit) begin
            r_state       <= S_OVER;
            r_hit         <= w_hit_now;
            r_game_status <= 1'b0;
            r_game_over   <= 1'b1;
          end
`ifdef GAME_CTRL_PAUSE_EN
          else if (r_start_p) begin
            r_state       <= S_PAUSE;
            r_hit         <= 1'b0;
            r_game_status <= 1'b0;
            r_game_over   <= 1'b0;
          end
`endif
          else begin
            r_hit <= w_hit_now | (r_hit & ~r_frame_end);
            if (r_frame_end) begin
              if (r_frame_cnt == DIV_LAST) begin
                r_frame_cnt <= 8'd0;
                r_score     <= bcd_inc(r_score);
              end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
            end
          end
        end
`ifdef GAME_CTRL_PAUSE_EN
        S_PAUSE: begin
          r_hit <= 1'b0;
          if (r_start_p) begin
            r_state       <= S_RUN;
            r_game_status <= 1'b1;
            r_game_over   <= 1'b0;
          end
        end
`endif
        default: begin
          r_state       <= S_IDLE;
          r_hit         <= 1'b0;
          r_game_status <= 1'b0;
          r_game_over   <= 1'b0;
        end
      endcase
    end
  end

  assign fresh       = r_fresh;
  assign game_status = r_game_status;
  assign game_over   = r_game_over;
  assign score       = r_score;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: vector table, timing sequences and randomized frames against a
// history-based reference model; a SCORE_DIV=1 instance reaches score saturation.
module tb_game_ctrl;
  localparam int ROWS = 480;
  localparam int DIV  = 6;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic [8:0]  row_addr = 9'd0;
  logic [9:0]  col_addr = 10'd0;
  logic        dino_px = 1'b0;
  logic        obst_px = 1'b0;
  logic        fresh, game_status, game_over;
  logic [15:0] score;
  logic        f_fresh, f_status, f_over;
  logic [15:0] f_score;

  int checks = 0;
  int errors = 0;
  int tcnt = 0;
  int t_fall = -1;
  int t_over = -1;
  int falls = 0;
  logic prev_fresh = 1'b0;
  logic prev_over = 1'b0;

  game_ctrl #(.ACTIVE_ROWS(480), .SCORE_DIV(6)) dut (
    .clk(clk), .RESET_N(RESET_N), .START(START), .row_addr(row_addr), .col_addr(col_addr),
    .dino_px(dino_px), .obst_px(obst_px), .fresh(fresh), .game_status(game_status),
    .game_over(game_over), .score(score));

  game_ctrl #(.ACTIVE_ROWS(480), .SCORE_DIV(1)) dut_fast (
    .clk(clk), .RESET_N(RESET_N), .START(START), .row_addr(row_addr), .col_addr(col_addr),
    .dino_px(dino_px), .obst_px(obst_px), .fresh(f_fresh), .game_status(f_status),
    .game_over(f_over), .score(f_score));

  always #5 clk = ~clk;

  // Reference model: input histories give the pin-to-use delays; score kept as an integer.
  bit st_h[5];
  bit ac_h[4];
  bit m_run, m_over, m_pause, m_hit, m_fresh;
  int m_count, m_frames;

  function automatic logic [15:0] to_bcd(input int c);
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) st_h[i] = 1'b0;
    for (int i = 0; i < 4; i++) ac_h[i] = 1'b0;
    m_run = 0; m_over = 0; m_pause = 0; m_hit = 0; m_fresh = 0;
    m_count = 0; m_frames = 0;
  endtask

  task automatic model_step();
    bit sp, fe, hn;
    for (int i = 4; i > 0; i--) st_h[i] = st_h[i-1];
    for (int i = 3; i > 0; i--) ac_h[i] = ac_h[i-1];
    st_h[0] = START;
    ac_h[0] = (int'(row_addr) < ROWS);
    sp = st_h[3] & ~st_h[4];
    fe = ac_h[3] & ~ac_h[2];
    hn = dino_px & obst_px & (int'(col_addr) < 640) & ac_h[0];
    m_fresh = ac_h[0];
    if (m_run) begin
      if (fe && m_hit) begin
        m_run = 0; m_over = 1; m_hit = hn;
      end
`ifdef GAME_CTRL_PAUSE_EN
      else if (sp) begin
        m_run = 0; m_pause = 1; m_hit = 0;
      end
`endif
      else begin
        if (fe) begin
          m_frames++;
          if (m_frames == DIV) begin
            m_frames = 0;
            if (m_count < 9999) m_count++;
          end
        end
        m_hit = hn | (m_hit & ~fe);
      end
    end else if (m_pause) begin
      m_hit = 0;
      if (sp) begin m_pause = 0; m_run = 1; end
    end else if (sp) begin
      m_run = 1; m_over = 0; m_count = 0; m_frames = 0; m_hit = 0;
    end else begin
      m_hit = hn | (m_hit & ~fe);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_cycle();
    checks++;
    if (fresh !== m_fresh || game_status !== m_run || game_over !== m_over ||
        score !== to_bcd(m_count)) begin
      errors++;
      $display("FAIL cycle t=%0t: got fresh=%b status=%b over=%b score=%h expected %b %b %b %h",
               $time, fresh, game_status, game_over, score, m_fresh, m_run, m_over, to_bcd(m_count));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    tcnt++;
    check_cycle();
    if (prev_fresh && !fresh) begin falls++; t_fall = tcnt; end
    if (!prev_over && game_over) t_over = tcnt;
    prev_fresh = fresh;
    prev_over  = game_over;
  endtask

  task automatic run_frame(input bit hit, input logic [9:0] hcol);
    int rows[10] = '{0, 100, 200, 300, 400, 479, 480, 490, 500, 510};
    for (int i = 0; i < 10; i++) begin
      row_addr = 9'(rows[i]);
      dino_px  = hit && (rows[i] == 300);
      obst_px  = dino_px;
      col_addr = (rows[i] == 300) ? hcol : 10'd5;
      tick();
    end
    dino_px = 1'b0;
    obst_px = 1'b0;
  endtask

  task automatic run_frame_rand();
    int rows[10] = '{0, 100, 200, 300, 400, 479, 480, 490, 500, 510};
    for (int i = 0; i < 10; i++) begin
      row_addr = 9'(rows[i]);
      col_addr = 10'($urandom_range(0, 1023));
      dino_px  = ($urandom_range(0, 3) == 0);
      obst_px  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 24) == 0) START = ~START;
      tick();
    end
    dino_px = 1'b0;
    obst_px = 1'b0;
  endtask

  task automatic run_compact();
    int rows[4] = '{0, 480, 500, 510};
    for (int i = 0; i < 4; i++) begin
      row_addr = 9'(rows[i]);
      tick();
    end
  endtask

  task automatic press_start();
    row_addr = 9'd0;
    col_addr = 10'd0;
    START = 1'b1;
    repeat (3) tick();
    START = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_cycle();
    RESET_N = 1'b1;
    prev_fresh = 1'b0;
    prev_over  = 1'b0;
  endtask

  typedef struct {
    bit          press;
    int          frames;
    bit          hit;
    logic [9:0]  hcol;
    logic [15:0] exp_score;
    bit          exp_status;
    bit          exp_over;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within the time bound");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    int   lat;
    tbl[0] = '{1'b0,  3, 1'b0, 10'd0,   16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 60, 1'b0, 10'd0,   16'h0010, 1'b1, 1'b0};
    tbl[2] = '{1'b0,  7, 1'b1, 10'd700, 16'h0011, 1'b1, 1'b0};
    tbl[3] = '{1'b0,  1, 1'b1, 10'd120, 16'h0011, 1'b0, 1'b1};
    tbl[4] = '{1'b0,  5, 1'b0, 10'd0,   16'h0011, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 12, 1'b0, 10'd0,   16'h0002, 1'b1, 1'b0};
    tbl[6] = '{1'b0,  2, 1'b1, 10'd120, 16'h0002, 1'b0, 1'b1};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {13'd0, fresh, game_status, game_over, score}, 32'd0);
    RESET_N = 1'b1;

    row_addr = 9'd479;
    tick();
    check("fresh_before_480", {31'd0, fresh}, 32'd1);
    row_addr = 9'd480;
    tick();
    check("fresh_fall_at_480", {31'd0, fresh}, 32'd0);
    row_addr = 9'd500;
    repeat (2) tick();

    falls = 0;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].press) press_start();
      for (int f = 0; f < tbl[i].frames; f++) run_frame(tbl[i].hit, tbl[i].hcol);
      check($sformatf("vec%0d_score", i), {16'd0, score}, {16'd0, tbl[i].exp_score});
      check($sformatf("vec%0d_status", i), {31'd0, game_status}, {31'd0, tbl[i].exp_status});
      check($sformatf("vec%0d_over", i), {31'd0, game_over}, {31'd0, tbl[i].exp_over});
      if (i == 0) check("idle_fresh_falls", falls, 3);
    end

    // Restart from OVER: latency from the START pin to game_status
    row_addr = 9'd0;
    START = 1'b1;
    lat = 0;
    while (!game_status && lat < 20) begin
      tick();
      lat++;
    end
    check("start_latency", lat, 4);
    START = 1'b0;
    repeat (3) tick();
    repeat (3) run_frame(1'b0, 10'd0);
    check("restart_running", {30'd0, game_status, game_over}, 32'd2);
    check("restart_score", {16'd0, score}, 32'h0000);
    repeat (249) run_frame(1'b0, 10'd0);
    check("score_0042", {16'd0, score}, 32'h0042);

    // Asynchronous reset mid-game, observed before any clock edge
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_reset", {13'd0, fresh, game_status, game_over, score}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_cycle();
    RESET_N = 1'b1;
    prev_fresh = 1'b0;
    prev_over  = 1'b0;
    row_addr = 9'd0;
    tick();

    // Collision latency and frozen score
    press_start();
    repeat (6) run_frame(1'b0, 10'd0);
    t_fall = -1;
    t_over = -1;
    run_frame(1'b1, 10'd120);
    check("collision_latency", t_over - t_fall, 2);
    repeat (2) run_frame(1'b0, 10'd0);
    check("collision_frozen", {16'd0, score}, 32'h0001);
    check("collision_over", {30'd0, game_status, game_over}, 32'd1);

`ifdef GAME_CTRL_PAUSE_EN
    do_reset();
    press_start();
    repeat (12) run_frame(1'b0, 10'd0);
    press_start();
    check("pause_status", {30'd0, game_status, game_over}, 32'd0);
    repeat (10) run_frame(1'b1, 10'd120);
    check("pause_held", {16'd0, score}, 32'h0002);
    press_start();
    repeat (6) run_frame(1'b0, 10'd0);
    check("pause_resume", {16'd0, score}, 32'h0003);
`endif

    // Randomized frames checked every cycle by the model
    for (int f = 0; f < 150; f++) run_frame_rand();
    START = 1'b0;
    repeat (6) tick();

    // Saturation on the divide-by-one instance
    do_reset();
    press_start();
    for (int f = 0; f < 9998; f++) run_compact();
    check("fast_score_9998", {16'd0, f_score}, 32'h9998);
    repeat (12) run_compact();
    check("fast_score_sat", {16'd0, f_score}, 32'h9999);
    check("fast_running", {30'd0, f_status, f_over}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the dinosaur runner. It derives the per-frame tick `fresh` from the VGA scan position and runs the IDLE/RUN/OVER state machine that drives `game_status`. It detects dinosaur/obstacle pixel overlap and keeps a 4-digit BCD score. It sits upstream of the jump and obstacle stages, which advance on the falling edge of `fresh` while `game_status` is high, and it consumes their `px` outputs.

## Interface
- `ACTIVE_ROWS`, 480: visible rows per frame; `fresh` is high while `row_addr < ACTIVE_ROWS`.
- `SCORE_DIV`, 6: frames per score increment, range 1..255.
- `clk` in 1: system clock, the same clock the VGA counters run on.
- `RESET_N` in 1: asynchronous, active-low reset.
- `START` in 1: raw start button, asynchronous to `clk`.
- `row_addr` in 9: current VGA row.
- `col_addr` in 10: current VGA column; used only to qualify the visible area (`< 640`).
- `dino_px` in 1: dinosaur pixel from the jump stage.
- `obst_px` in 1: obstacle pixel from the obstacle stage.
- `fresh` out 1: frame tick, registered.
- `game_status` out 1: 1 while running, registered.
- `game_over` out 1: 1 in OVER, registered.
- `score` out 16: four BCD digits; `[15:12]` is thousands.

## Operation
- **START conditioning**
  - 2-flop synchroniser, then rising-edge detect, giving `start_p` (one clk).
- **Frame tick**
  - `fresh <= (row_addr < ACTIVE_ROWS)`.
  - `frame_end` is asserted for one clk when registered `fresh` goes 1→0.
- **Collision**
  - `hit_lat` is set on any clk where `dino_px & obst_px & (col_addr < 640) & (row_addr < ACTIVE_ROWS)`.
  - `hit_lat` clears on `frame_end` after being evaluated, and on every entry to RUN.
- **States**
  - IDLE: `game_status=0`, `game_over=0`. `start_p` → RUN.
  - RUN: `game_status=1`.
    - `frame_end & hit_lat` → OVER.
    - Otherwise, on `frame_end`, the frame counter increments. When it reaches `SCORE_DIV-1` it wraps to 0 and `score` increments.
  - OVER: `game_status=0`, `game_over=1`, `score` frozen. `start_p` → RUN.
- **Entry to RUN** (from IDLE or OVER): clears `score`, the frame counter and `hit_lat`.
- **Score arithmetic**
  - BCD increment with per-digit carry at 9.
  - Saturates at 16'h9999; further increments are ignored.
- **Simultaneous events**
  - `start_p` in RUN is ignored unless the pause macro is defined.
  - `frame_end` with `start_p` in IDLE/OVER: the transition to RUN wins, and that `frame_end` does not score.

## Timing
- Reset values: state IDLE, `fresh=0`, `game_status=0`, `game_over=0`, `score=16'h0000`, `hit_lat=0`, frame counter 0, synchroniser flops 0.
- `START` pin → `start_p`: 3 clk. `start_p` → `game_status=1`: 1 clk.
- `row_addr` crosses `ACTIVE_ROWS` → `fresh` falls: 1 clk. `frame_end` follows 1 clk later.
- `frame_end` with hit → `game_status=0` and `game_over=1` on the next clk. Downstream stages therefore see `game_status` still high at the `fresh` negedge of the colliding frame; that final step is intended.
- Score update: 1 clk after the qualifying `frame_end`.
- `RESET_N` low mid-game: all state returns to reset values immediately. `fresh` stays 0 until the first clk after release.

## Configuration
- Macro: `GAME_CTRL_PAUSE_EN`.
- **Defined:** adds a PAUSE state.
  - `start_p` in RUN → PAUSE: `game_status=0`, `game_over=0`, score and frame counter held.
  - `hit_lat` is held clear while in PAUSE.
  - `start_p` in PAUSE → RUN without clearing the score.
- **Undefined:** no PAUSE state; `start_p` in RUN is ignored.

## Test plan
- Reset then idle: `RESET_N` 0→1, scan 3 frames, no START → `game_status=0`, `score=0000`, `fresh` toggles once per frame with its falling edge 1 clk after `row_addr` reaches 480.
- Start and score: pulse START, run 60 frames with no overlap, `SCORE_DIV=6` → `game_status=1` 4 clk after the pin edge, `score=16'h0010`.
- Collision: in RUN, assert `dino_px=obst_px=1` for 1 clk at row 300, col 120 → `game_over=1` and `game_status=0` 2 clk after `fresh` falls; `score` frozen. Overlap at col 700 only → no effect.
- Restart from OVER: START pulse → `score=0000`, `game_over=0`, `game_status=1`; a new hit is required to end the game.
- Saturation: force `score=16'h9998`, run 12 frames → `score=16'h9999` and stays there.
- Asynchronous reset mid-RUN: drop `RESET_N` for 1 clk at `score=16'h0042` → all outputs return to reset values without waiting for a clock edge. With `GAME_CTRL_PAUSE_EN` defined: START in RUN → `game_status=0` and `score` held across 10 frames; second START resumes counting from the held value.
